// File: rtl/arbitro_paralelo_serial_pkg.sv
// Shared link definitions for the paraleloSerial word-slot scheduler:
// K28.5 comma, default geometry, FSM encodings and the round-robin index helper.
package arbitro_paralelo_serial_pkg;

  localparam int unsigned WORD_BITS_DEF  = 10;
  localparam int unsigned SYNC_WORDS_DEF = 4;
  localparam logic [9:0]  IDLE_WORD_DEF  = 10'b0011111010;

  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Circular requester index: (base + off) modulo n.
  function automatic int unsigned rrIndex(input int unsigned base, input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/arbitro_paralelo_serial_rr.sv
// Combinational requester selector: first set req at or after ptr (circular).
// Define ARB_FIXED_PRIORITY_EN to select the lowest-index request instead.
module arbitro_rr
  import arbitro_paralelo_serial_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] selOh_c,
  output logic [PTR_W-1:0]   selIdx_c,
  output logic               valid_c
);

  logic [PTR_W-1:0] base;
  logic [PTR_W-1:0] cand;

`ifdef ARB_FIXED_PRIORITY_EN
  assign base = '0;
`else
  assign base = ptr;
`endif

  always_comb begin
    selOh_c  = '0;
    selIdx_c = '0;
    valid_c  = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'(rrIndex(32'(base), i, NUM_REQ));
      if (!valid_c && req[cand]) begin
        valid_c        = 1'b1;
        selIdx_c       = cand;
        selOh_c[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_paralelo_serial.sv
// Word-slot scheduler sharing one serial lane between NUM_REQ requesters,
// one word per WORD_BITS-cycle slot. ARB_FIXED_PRIORITY_EN selects fixed priority.
module arbitro_paralelo_serial
  import arbitro_paralelo_serial_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_BITS  = WORD_BITS_DEF,
  parameter int unsigned SYNC_WORDS = SYNC_WORDS_DEF,
  parameter logic [WORD_BITS-1:0] IDLE_WORD = WORD_BITS'(IDLE_WORD_DEF)
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WORD_BITS-1:0]   datos,
  input  logic                           pausa,
  output logic [WORD_BITS-1:0]           palabra,
  output logic                           carga,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           sincronizado,
  output logic [$clog2(WORD_BITS)-1:0]   slot
);

  localparam int unsigned SLOT_W = $clog2(WORD_BITS);
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(SYNC_WORDS + 1);

  logic [0:0]           state, stateNext;
  logic [CNT_W-1:0]     syncCnt, syncCntNext;
  logic [PTR_W-1:0]     ptr, ptrNext;
  logic [SLOT_W-1:0]    slotNext;
  logic [WORD_BITS-1:0] palabraNext;
  logic                 cargaNext;
  logic [NUM_REQ-1:0]   ackNext, gntNext;
  logic                 sincNext;
  logic                 boundary_c;

  logic [NUM_REQ-1:0]   selOh;
  logic [PTR_W-1:0]     selIdx;
  logic                 selValid;

  arbitro_rr #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req      (req),
    .ptr      (ptr),
    .selOh_c  (selOh),
    .selIdx_c (selIdx),
    .valid_c  (selValid)
  );

  assign boundary_c = (slot == SLOT_W'(WORD_BITS - 1));

  // Next-state and next-output logic; everything only moves on the boundary cycle.
  always_comb begin
    stateNext   = state;
    syncCntNext = syncCnt;
    ptrNext     = ptr;
    palabraNext = palabra;
    cargaNext   = 1'b0;
    ackNext     = '0;
    gntNext     = gnt;
    sincNext    = sincronizado;
    slotNext    = boundary_c ? '0 : SLOT_W'(slot + 1'b1);

    if (boundary_c) begin
      cargaNext = 1'b1;
      case (state)
        ST_SYNC: begin
          palabraNext = IDLE_WORD;
          gntNext     = '0;
          syncCntNext = CNT_W'(syncCnt + 1'b1);
          if (syncCnt == CNT_W'(SYNC_WORDS - 1)) begin
            stateNext = ST_ACTIVE;
            sincNext  = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (pausa || !selValid) begin
            palabraNext = IDLE_WORD;
            gntNext     = '0;
          end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
              if (selOh[i]) palabraNext = datos[i*WORD_BITS +: WORD_BITS];
            end
            gntNext = selOh;
            ackNext = selOh;
`ifdef ARB_FIXED_PRIORITY_EN
            ptrNext = '0;
`else
            ptrNext = (selIdx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(selIdx + 1'b1);
`endif
          end
        end
        default: stateNext = ST_SYNC;
      endcase
    end
  end

  // State and output registers; reset restarts link sync from scratch.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state        <= ST_SYNC;
      syncCnt      <= '0;
      ptr          <= '0;
      slot         <= '0;
      palabra      <= IDLE_WORD;
      carga        <= 1'b0;
      ack          <= '0;
      gnt          <= '0;
      sincronizado <= 1'b0;
    end else begin
      state        <= stateNext;
      syncCnt      <= syncCntNext;
      ptr          <= ptrNext;
      slot         <= slotNext;
      palabra      <= palabraNext;
      carga        <= cargaNext;
      ack          <= ackNext;
      gnt          <= gntNext;
      sincronizado <= sincNext;
    end
  end

endmodule
